// File: rtl/conv_window_sequencer_if.sv
// Feature-map read-address handshake between the window sequencer (master)
// and the feature-map reader (slave).
interface conv_window_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] SEQ_Addr;
  logic              SEQ_Valid;
  logic              SEQ_Last;
  logic              SEQ_Ready;

  modport master (
    output SEQ_Addr,
    output SEQ_Valid,
    output SEQ_Last,
    input  SEQ_Ready
  );

  modport slave (
    input  SEQ_Addr,
    input  SEQ_Valid,
    input  SEQ_Last,
    output SEQ_Ready
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// Convolution loop sequencer: walks channel/row/col/kernel taps and issues read addresses.
// Optional stride-2 support (SEQ_Stride2 port) when CONV_SEQ_STRIDE2_EN is defined.
module conv_window_sequencer #(
  parameter int DIM_W  = 8,
  parameter int CH_W   = 8,
  parameter int ADDR_W = 16,
  parameter int K      = 3
) (
  input  logic                  SEQ_Clk,
  input  logic                  SEQ_Reset,
  input  logic                  SEQ_Start,
  input  logic [DIM_W-1:0]      SEQ_Width,
  input  logic [DIM_W-1:0]      SEQ_Height,
  input  logic [CH_W-1:0]       SEQ_Channels,
`ifdef CONV_SEQ_STRIDE2_EN
  input  logic                  SEQ_Stride2,
`endif
  conv_window_sequencer_if.master rd,
  output logic                  SEQ_ChEn,
  output logic                  SEQ_ChClr,
  output logic                  SEQ_Busy,
  output logic                  SEQ_Done,
  output logic                  SEQ_Err
);

  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam logic [KW-1:0]    K_LAST = KW'(K - 1);
  localparam logic [DIM_W-1:0] K_DIM  = DIM_W'(K);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;

  state_t state_q, state_d;

  logic [DIM_W-1:0]  w_q, w_d, h_q, h_d;
  logic [CH_W-1:0]   c_q, c_d, ch_q, ch_d;
  logic [DIM_W-1:0]  row_q, row_d, col_q, col_d;
  logic [KW-1:0]     kr_q, kr_d, kc_q, kc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d, last_q, last_d;
  logic              chen_q, chen_d, chclr_q, chclr_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              s2_cur;
`ifdef CONV_SEQ_STRIDE2_EN
  logic              s2_q, s2_d;
`endif

  logic              cfg_ok, hs;
  logic [DIM_W-1:0]  lim_w, lim_h;
  logic              kc_fin, kr_fin, col_fin, row_fin, ch_fin;

  // True when p is the last window position, i.e. p+S would pass lim (= dim-K).
  function automatic logic pos_fin(input logic [DIM_W-1:0] p,
                                   input logic [DIM_W-1:0] lim,
                                   input logic             s2);
    logic [DIM_W+1:0] nx;
    nx = {2'b00, p} + (DIM_W+2)'({s2, ~s2});
    return nx > {2'b00, lim};
  endfunction

  function automatic logic [ADDR_W-1:0] addr_of(input logic [CH_W-1:0]  ch,
                                                input logic [DIM_W-1:0] w,
                                                input logic [DIM_W-1:0] h,
                                                input logic [DIM_W-1:0] row,
                                                input logic [DIM_W-1:0] col,
                                                input logic [KW-1:0]    kr,
                                                input logic [KW-1:0]    kc);
    return ADDR_W'(ch) * ADDR_W'(w) * ADDR_W'(h)
         + (ADDR_W'(row) + ADDR_W'(kr)) * ADDR_W'(w)
         + ADDR_W'(col) + ADDR_W'(kc);
  endfunction

  assign cfg_ok = (SEQ_Width >= K_DIM) && (SEQ_Height >= K_DIM) && (SEQ_Channels != '0);
  assign hs     = valid_q && rd.SEQ_Ready;
  assign lim_w  = w_q - K_DIM;
  assign lim_h  = h_q - K_DIM;

`ifdef CONV_SEQ_STRIDE2_EN
  assign s2_cur = (state_q == ST_LOAD) ? SEQ_Stride2 : s2_q;
`else
  assign s2_cur = 1'b0;
`endif

  assign kc_fin  = (kc_q == K_LAST);
  assign kr_fin  = (kr_q == K_LAST);
  assign col_fin = pos_fin(col_q, lim_w, s2_cur);
  assign row_fin = pos_fin(row_q, lim_h, s2_cur);
  assign ch_fin  = (ch_q == c_q - CH_W'(1));

  always_ff @(posedge SEQ_Clk) begin
    if (SEQ_Reset) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      c_q     <= '0;
      ch_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
      kr_q    <= '0;
      kc_q    <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      chen_q  <= 1'b0;
      chclr_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CONV_SEQ_STRIDE2_EN
      s2_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      c_q     <= c_d;
      ch_q    <= ch_d;
      row_q   <= row_d;
      col_q   <= col_d;
      kr_q    <= kr_d;
      kc_q    <= kc_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      chen_q  <= chen_d;
      chclr_q <= chclr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef CONV_SEQ_STRIDE2_EN
      s2_q    <= s2_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (SEQ_Start) state_d = cfg_ok ? ST_LOAD : ST_DONE;
      ST_LOAD: state_d = ST_RUN;
      ST_RUN:  if (hs && last_q) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered, so their next values follow the next state, not the current one.
  always_comb begin
    w_d     = w_q;
    h_d     = h_q;
    c_d     = c_q;
    ch_d    = ch_q;
    row_d   = row_q;
    col_d   = col_q;
    kr_d    = kr_q;
    kc_d    = kc_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    last_d  = last_q;
    err_d   = err_q;
    chen_d  = 1'b0;
`ifdef CONV_SEQ_STRIDE2_EN
    s2_d    = s2_cur;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (SEQ_Start) begin
          if (cfg_ok) begin
            w_d   = SEQ_Width;
            h_d   = SEQ_Height;
            c_d   = SEQ_Channels;
            err_d = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        ch_d    = '0;
        row_d   = '0;
        col_d   = '0;
        kr_d    = '0;
        kc_d    = '0;
        addr_d  = '0;
        valid_d = 1'b1;
        last_d  = (c_q == CH_W'(1)) && (K_LAST == '0)
               && pos_fin('0, lim_w, s2_cur) && pos_fin('0, lim_h, s2_cur);
      end
      ST_RUN: begin
        if (hs) begin
          chen_d = kc_fin && kr_fin && col_fin && row_fin;
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            if (!kc_fin) begin
              kc_d = kc_q + KW'(1);
            end else begin
              kc_d = '0;
              if (!kr_fin) begin
                kr_d = kr_q + KW'(1);
              end else begin
                kr_d = '0;
                if (!col_fin) begin
                  col_d = col_q + DIM_W'({s2_cur, ~s2_cur});
                end else begin
                  col_d = '0;
                  if (!row_fin) begin
                    row_d = row_q + DIM_W'({s2_cur, ~s2_cur});
                  end else begin
                    row_d = '0;
                    ch_d  = ch_q + CH_W'(1);
                  end
                end
              end
            end
            addr_d = addr_of(ch_d, w_q, h_q, row_d, col_d, kr_d, kc_d);
            last_d = (ch_d == c_q - CH_W'(1)) && (kc_d == K_LAST) && (kr_d == K_LAST)
                  && pos_fin(col_d, lim_w, s2_cur) && pos_fin(row_d, lim_h, s2_cur);
          end
        end
      end
      default: begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
    chclr_d = (state_d != ST_LOAD);
  end

  assign rd.SEQ_Addr  = addr_q;
  assign rd.SEQ_Valid = valid_q;
  assign rd.SEQ_Last  = last_q;
  assign SEQ_ChEn     = chen_q;
  assign SEQ_ChClr    = chclr_q;
  assign SEQ_Busy     = busy_q;
  assign SEQ_Done     = done_q;
  assign SEQ_Err      = err_q;

  logic unused_ok;
  assign unused_ok = ch_fin;

endmodule
